// File: rtl/commit_trace_fifo.sv
// Captures one commit record per retired instruction into a DEPTH-entry FIFO, drained by a ready/valid trace port.
// Latency: a record captured at edge N is visible on tr_* with tr_valid=1 after edge N (no same-cycle bypass).
// Backpressure: tr_ready=0 holds the head stable; a commit arriving while full without a pop is dropped and counted.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       commit_valid,
  input  logic [63:0]                pc_in,
  input  logic [31:0]                instr_in,
  input  logic [63:0]                valE,
  input  logic [63:0]                read_data,
  input  logic [63:0]                write_data,
  input  logic                       MemtoReg,
  input  logic                       RegWrite,
  input  logic                       MemWrite,
  input  logic                       Branch,
  input  logic                       BranchZero,
  input  logic [63:0]                pcb,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [63:0]                tr_pc,
  output logic [31:0]                tr_instr,
  output logic [63:0]                tr_result,
  output logic [63:0]                tr_store_data,
  output logic [63:0]                tr_next_pc,
  output logic [3:0]                 tr_flags,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic [CNT_W-1:0]           retired_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] result;
    logic [63:0] store_data;
    logic [63:0] next_pc;
    logic [3:0]  flags;
  } rec_t;

  rec_t          mem [DEPTH];
  rec_t          cap;
  rec_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          taken;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          drop;

  // Build the record from the retiring instruction's datapath signals.
  always_comb begin
    taken          = Branch & BranchZero;
    cap.pc         = pc_in;
    cap.instr      = instr_in;
    cap.result     = MemtoReg ? read_data : valE;
    cap.store_data = write_data;
    cap.next_pc    = taken ? pcb : pc_in + 64'd4;
    cap.flags      = {taken, MemWrite, RegWrite, MemtoReg};
  end

  // Full/empty come from the registered count, so a push is never visible in its own cycle.
  always_comb begin
    full  = (count == CW'(DEPTH));
    empty = (count == '0);
    pop   = !empty & tr_ready;
    push  = commit_valid & (!full | pop);
    drop  = commit_valid & full & !pop;
  end

  // Storage is never cleared; a commit during reset is not written.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= cap;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Status: sticky overflow plus saturating retired/dropped counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      retired_cnt <= '0;
    end else begin
      if (drop) overflow <= 1'b1;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      if (commit_valid && retired_cnt != '1) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Head entry drives the trace port; it only moves on a pop, so it holds under backpressure.
  always_comb begin
    head          = mem[rd_ptr];
    tr_valid      = !empty;
    tr_pc         = head.pc;
    tr_instr      = head.instr;
    tr_result     = head.result;
    tr_store_data = head.store_data;
    tr_next_pc    = head.next_pc;
    tr_flags      = head.flags;
    fifo_count    = count;
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
module tb_commit_trace_fifo;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] result;
    logic [63:0] store_data;
    logic [63:0] next_pc;
    logic [3:0]  flags;
  } rec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic [63:0] pc_in = '0;
  logic [31:0] instr_in = '0;
  logic [63:0] valE = '0;
  logic [63:0] read_data = '0;
  logic [63:0] write_data = '0;
  logic        MemtoReg = 1'b0;
  logic        RegWrite = 1'b0;
  logic        MemWrite = 1'b0;
  logic        Branch = 1'b0;
  logic        BranchZero = 1'b0;
  logic [63:0] pcb = '0;
  logic        tr_valid;
  logic        tr_ready = 1'b0;
  logic [63:0] tr_pc;
  logic [31:0] tr_instr;
  logic [63:0] tr_result;
  logic [63:0] tr_store_data;
  logic [63:0] tr_next_pc;
  logic [3:0]  tr_flags;
  logic [4:0]  fifo_count;
  logic        overflow;
  logic [31:0] drop_cnt;
  logic [31:0] retired_cnt;

  int   errors = 0;
  int   checks = 0;
  int   n_pops = 0;
  rec_t exp_q[$];

  commit_trace_fifo #(.DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .commit_valid(commit_valid), .pc_in(pc_in),
    .instr_in(instr_in), .valE(valE), .read_data(read_data), .write_data(write_data),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite), .Branch(Branch),
    .BranchZero(BranchZero), .pcb(pcb), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_pc(tr_pc), .tr_instr(tr_instr), .tr_result(tr_result),
    .tr_store_data(tr_store_data), .tr_next_pc(tr_next_pc), .tr_flags(tr_flags),
    .fifo_count(fifo_count), .overflow(overflow), .drop_cnt(drop_cnt),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head record is compared against the scoreboard front.
  always @(negedge clk) begin
    if (!reset && tr_valid && tr_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_record: got pc 0x%0h expected no record", tr_pc);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rec_pc", tr_pc, e.pc);
        chk("rec_instr", {32'd0, tr_instr}, {32'd0, e.instr});
        chk("rec_result", tr_result, e.result);
        chk("rec_store_data", tr_store_data, e.store_data);
        chk("rec_next_pc", tr_next_pc, e.next_pc);
        chk("rec_flags", {60'd0, tr_flags}, {60'd0, e.flags});
      end
      n_pops++;
    end
  end

  // Drive a commit and, when it is expected to be accepted, queue its hand-computed record.
  task automatic setup_commit(input logic [63:0] pc, input logic [31:0] ins,
                              input logic [63:0] ve, input logic [63:0] rd, input logic [63:0] wd,
                              input logic m2r, input logic rw, input logic mw,
                              input logic br, input logic bz, input logic [63:0] tgt,
                              input logic [63:0] e_res, input logic [63:0] e_next,
                              input logic [3:0] e_flags, input logic accept);
    rec_t e;
    pc_in = pc; instr_in = ins; valE = ve; read_data = rd; write_data = wd;
    MemtoReg = m2r; RegWrite = rw; MemWrite = mw; Branch = br; BranchZero = bz; pcb = tgt;
    commit_valid = 1'b1;
    if (accept) begin
      e.pc = pc; e.instr = ins; e.result = e_res; e.store_data = wd;
      e.next_pc = e_next; e.flags = e_flags;
      exp_q.push_back(e);
    end
  endtask

  task automatic finish_commit();
    @(posedge clk); #1;
    commit_valid = 1'b0;
  endtask

  // Plain ALU op: RegWrite only, writeback = valE, next pc = pc + 4.
  task automatic alu_commit(input logic [63:0] pc, input logic [63:0] ve,
                            input logic [63:0] e_next, input logic accept);
    setup_commit(pc, 32'h0000_0033, ve, 64'hDEAD, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                 64'h0, ve, e_next, 4'b0010, accept);
    finish_commit();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int cyc = 0;
    tr_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (fifo_count != 0 && cyc < 100);
    tr_ready = 1'b0;
    if (fifo_count != 0) begin
      errors++;
      $display("FAIL drain_timeout: got count %0d expected 0", fifo_count);
    end
    checks++;
    chk("queue_empty_after_drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int pops0;
    do_reset();

    // Reset state.
    @(negedge clk);
    chk("rst_tr_valid", {63'd0, tr_valid}, 64'd0);
    chk("rst_count", {59'd0, fifo_count}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_drop", {32'd0, drop_cnt}, 64'd0);
    chk("rst_retired", {32'd0, retired_cnt}, 64'd0);
    @(posedge clk); #1;

    // T1: single add; no bypass during the push cycle.
    setup_commit(64'h10, 32'h0020_81B3, 64'd5, 64'h77, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 64'h0, 64'd5, 64'h14, 4'b0000, 1'b1);
    @(negedge clk);
    chk("t1_no_bypass", {63'd0, tr_valid}, 64'd0);
    finish_commit();
    @(negedge clk);
    chk("t1_tr_valid", {63'd0, tr_valid}, 64'd1);
    chk("t1_count", {59'd0, fifo_count}, 64'd1);
    @(posedge clk); #1;
    drain();

    // T2: taken branch, not-taken branch, pc wrap at 2^64-4.
    setup_commit(64'h20, 32'h0000_0463, 64'd0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                 64'h8, 64'd0, 64'h8, 4'b1000, 1'b1);
    finish_commit();
    setup_commit(64'h24, 32'h0000_0463, 64'd9, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 64'h8, 64'd9, 64'h28, 4'b0000, 1'b1);
    finish_commit();
    alu_commit(64'hFFFF_FFFF_FFFF_FFFC, 64'd3, 64'h0, 1'b1);
    drain();

    // T3: load selects read_data; store carries write_data; head stable under backpressure.
    setup_commit(64'h30, 32'h0001_3183, 64'h40, 64'hAB, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                 64'h0, 64'hAB, 64'h34, 4'b0011, 1'b1);
    finish_commit();
    setup_commit(64'h34, 32'h0031_3023, 64'h100, 64'hCC, 64'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                 64'h0, 64'h100, 64'h38, 4'b0100, 1'b1);
    finish_commit();
    @(negedge clk);
    chk("t3_hold_pc_a", tr_pc, 64'h30);
    chk("t3_hold_result_a", tr_result, 64'hAB);
    @(negedge clk);
    chk("t3_hold_pc_b", tr_pc, 64'h30);
    chk("t3_retired", {32'd0, retired_cnt}, 64'd6);
    @(posedge clk); #1;
    drain();

    // T4: fill to 16, 17th commit dropped.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alu_commit(64'h1000 + 64'(4 * i), 64'(i), 64'h1004 + 64'(4 * i), 1'b1);
    end
    @(negedge clk);
    chk("t4_full_count", {59'd0, fifo_count}, 64'd16);
    chk("t4_no_overflow_yet", {63'd0, overflow}, 64'd0);
    @(posedge clk); #1;
    alu_commit(64'h2000, 64'd99, 64'h2004, 1'b0);
    @(negedge clk);
    chk("t4_overflow", {63'd0, overflow}, 64'd1);
    chk("t4_drop_cnt", {32'd0, drop_cnt}, 64'd1);
    chk("t4_retired", {32'd0, retired_cnt}, 64'd17);
    chk("t4_count_after_drop", {59'd0, fifo_count}, 64'd16);
    @(posedge clk); #1;

    // T5: full with simultaneous push and pop; order preserved across pointer wrap.
    tr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_commit(64'h3000 + 64'(4 * i), 64'(100 + i), 64'h3004 + 64'(4 * i), 1'b1);
    end
    tr_ready = 1'b0;
    @(negedge clk);
    chk("t5_count", {59'd0, fifo_count}, 64'd16);
    chk("t5_drop_cnt", {32'd0, drop_cnt}, 64'd1);
    chk("t5_retired", {32'd0, retired_cnt}, 64'd20);
    @(posedge clk); #1;
    drain();
    chk("t5_overflow_sticky", {63'd0, overflow}, 64'd1);

    // T6: reset mid-queue with a commit in the reset cycle; next commit emerges alone.
    for (int i = 0; i < 5; i++) begin
      alu_commit(64'h400 + 64'(4 * i), 64'(i), 64'h404 + 64'(4 * i), 1'b1);
    end
    @(negedge clk);
    chk("t6_count_5", {59'd0, fifo_count}, 64'd5);
    @(posedge clk); #1;
    reset = 1'b1;
    commit_valid = 1'b1;
    pc_in = 64'h999;
    @(posedge clk); #1;
    reset = 1'b0;
    commit_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t6_tr_valid", {63'd0, tr_valid}, 64'd0);
    chk("t6_count", {59'd0, fifo_count}, 64'd0);
    chk("t6_retired", {32'd0, retired_cnt}, 64'd0);
    chk("t6_drop", {32'd0, drop_cnt}, 64'd0);
    chk("t6_overflow", {63'd0, overflow}, 64'd0);
    @(posedge clk); #1;
    pops0 = n_pops;
    alu_commit(64'h500, 64'h5A, 64'h504, 1'b1);
    drain();
    chk("t6_single_record", 64'(n_pops - pops0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
